// File: rtl/fxp_mul_sat_pkg.sv
// Shared fixed-point definitions for the Q(ENT.FRAC) arithmetic chain.
//   - word width derivation: W = 1 + ENT + FRAC
//   - saturation bounds for the default format (MAX_POS / MAX_NEG)
//   - round-mode encoding used by the requantiser
package fxp_mul_sat_pkg;

  localparam int ENT_DEF  = 10;
  localparam int FRAC_DEF = 14;

  function automatic int fxp_width(input int ent, input int frac);
    return 1 + ent + frac;
  endfunction

  localparam int W_DEF = fxp_width(ENT_DEF, FRAC_DEF);

  localparam logic signed [W_DEF-1:0] MAX_POS = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic signed [W_DEF-1:0] MAX_NEG = {1'b1, {(W_DEF-1){1'b0}}};

  typedef enum logic {
    RND_TRUNC   = 1'b0,  // floor
    RND_HALF_UP = 1'b1   // add half an LSB, then floor
  } rnd_mode_e;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational requantiser: 2W-bit signed product with 2*FRAC fractional
// bits -> W-bit signed Q(ENT.FRAC) word, with optional round-half-up and
// saturation to the word range.
// Ports:
//   prod   in  2W  signed full-precision product
//   mode   in  1   RND_TRUNC / RND_HALF_UP
//   result out W   saturated, requantised value
//   ovf    out 1   result was clamped
module fxp_round_sat
  import fxp_mul_sat_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [2*W-1:0] prod,
  input  rnd_mode_e             mode,
  output logic signed [W-1:0]   result,
  output logic                  ovf
);

  // Bounds and rounding constant sign-extended to the 2W+1 working width,
  // one bit wider than the product so the rounding add can never wrap.
  localparam logic signed [2*W:0] HI   = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] LO   = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [2*W:0] HALF = {{(2*W+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic signed [2*W:0] sum;
  logic signed [2*W:0] r;

  always_comb begin
    sum    = {prod[2*W-1], prod} + ((mode == RND_HALF_UP) ? HALF : '0);
    r      = sum >>> FRAC;
    result = r[W-1:0];
    ovf    = 1'b0;
    if (r > HI) begin
      result = HI[W-1:0];
      ovf    = 1'b1;
    end else if (r < LO) begin
      result = LO[W-1:0];
      ovf    = 1'b1;
    end
  end

endmodule

// File: rtl/fxp_mul_sat.sv
// Pipelined signed fixed-point multiplier, Q(ENT.FRAC) x Q(ENT.FRAC) ->
// Q(ENT.FRAC), with selectable rounding, saturation and overflow stats.
// Operands presented in cycle k produce result/out_valid in cycle k+3
// (three register stages: operands, product, requantised result).
// Optional feature: define FXP_STATS_EN to implement ovf_sticky/ovf_count;
// otherwise both read 0 and clr_stats is ignored.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_valid     operands valid
//   a, b         signed operands, W bits
//   round_mode   0 truncate, 1 round half up (travels with operands)
//   clr_stats    clears ovf_sticky / ovf_count (wins over a coincident ovf)
//   out_valid    result valid
//   result       saturated product, W bits
//   ovf          this result was saturated
//   ovf_sticky   any saturation since reset/clear
//   ovf_count    saturation counter, sticks at all-ones
module fxp_mul_sat
  import fxp_mul_sat_pkg::*;
#(
  parameter  int ENT   = ENT_DEF,
  parameter  int FRAC  = FRAC_DEF,
  parameter  int CNT_W = 16,
  localparam int W     = fxp_width(ENT, FRAC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                round_mode,
  input  logic                clr_stats,
  output logic                out_valid,
  output logic signed [W-1:0] result,
  output logic                ovf,
  output logic                ovf_sticky,
  output logic [CNT_W-1:0]    ovf_count
);

  localparam int STAGES = 3;

  logic [STAGES-1:0]     vld_pipe;
  logic signed [W-1:0]   a1, b1;
  rnd_mode_e             m1, m2;
  logic signed [2*W-1:0] p2;
  logic signed [W-1:0]   res_c;
  logic                  ovf_c;

  // Datapath registers carry no reset; only the valid chain qualifies them.
  always_ff @(posedge clk) begin
    a1 <= a;
    b1 <= b;
    m1 <= rnd_mode_e'(round_mode);
    p2 <= (2*W)'(a1) * (2*W)'(b1);
    m2 <= m1;
  end

  fxp_round_sat #(.W(W), .FRAC(FRAC)) u_round_sat (
    .prod   (p2),
    .mode   (m2),
    .result (res_c),
    .ovf    (ovf_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
      if (vld_pipe[1]) begin
        result <= res_c;
        ovf    <= ovf_c;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];

`ifdef FXP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (vld_pipe[1] && ovf_c) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != '1) ovf_count <= ovf_count + CNT_W'(1);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_stats;
  assign ovf_sticky = 1'b0;
  assign ovf_count  = '0;
`endif

endmodule

// File: tb/tb_fxp_mul_sat.sv
// Scoreboard bench for fxp_mul_sat: directed vectors push expected
// result/ovf/arrival cycle into a queue; a negedge monitor pops and compares
// every out_valid beat, and flags any beat with nothing expected.
module tb_fxp_mul_sat;

  localparam int W     = 25;
  localparam int CNT_W = 4;
`ifdef FXP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] a = '0, b = '0;
  logic                round_mode = 1'b0;
  logic                clr_stats = 1'b0;
  logic                out_valid;
  logic signed [W-1:0] result;
  logic                ovf;
  logic                ovf_sticky;
  logic [CNT_W-1:0]    ovf_count;

  fxp_mul_sat #(.ENT(10), .FRAC(14), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .round_mode(round_mode), .clr_stats(clr_stats), .out_valid(out_valid),
    .result(result), .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [W-1:0] r;
    logic                o;
    int                  t;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.r);
        chk("ovf", ovf, e.o);
        chk("arrival_cycle", cyc, e.t);
      end
    end
  end

  task automatic issue(input longint av, input longint bv, input bit m,
                       input longint er, input bit eo);
    exp_t e;
    @(posedge clk); #1;
    a = W'(av); b = W'(bv); round_mode = m; in_valid = 1'b1;
    e.r = W'(er); e.o = eo; e.t = cyc + 3;
    q.push_back(e);
  endtask

  // Valid sample that must never emerge (reset will flush it).
  task automatic issue_lost(input longint av, input longint bv);
    @(posedge clk); #1;
    a = W'(av); b = W'(bv); round_mode = 1'b0; in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 25'sh0ffffff; b = 25'sh0ffffff;  // junk that would overflow
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_count", ovf_count, 0);
    reset = 1'b0;

    // Basic product and rounding
    issue(24576, -32768, 0, -49152, 0);
    issue(1, 8192, 0, 0, 0);
    issue(1, 8192, 1, 1, 0);
    issue(-1, 8192, 0, -1, 0);
    issue(-1, 8192, 1, 0, 0);
    issue(-16777216, 16384, 0, -16777216, 0);   // exactly MAX_NEG, no clamp
    idle(5);

    // Saturation, both directions
    issue(8388608, 8388608, 0, 16777215, 1);
    issue(8388608, -8388608, 0, -16777216, 1);
    issue(-16777216, -16777216, 0, 16777215, 1);
    idle(5);
    chk("sticky_after_3ovf", ovf_sticky, STATS ? 1 : 0);
    chk("count_after_3ovf", ovf_count, STATS ? 3 : 0);

    // Stream with valid pattern 11011011
    issue(16384, 16384, 0, 16384, 0);
    issue(-16384, 16384, 0, -16384, 0);
    idle(1);
    issue(49152, -8192, 0, -24576, 0);
    issue(3, 8192, 1, 2, 0);
    idle(1);
    issue(-3, 8192, 0, -2, 0);
    issue(-3, 8192, 1, -1, 0);
    idle(6);

    // Reset with two samples in flight
    issue_lost(16384, 16384);
    issue_lost(8388608, 8388608);
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("out_valid_after_reset", out_valid, 0);
    chk("result_after_reset", result, 0);
    chk("count_after_reset", ovf_count, 0);
    idle(6);

    // Counter saturation
    for (int i = 0; i < 20; i++) issue(8388608, 8388608, 0, 16777215, 1);
    idle(5);
    chk("count_saturates", ovf_count, STATS ? 15 : 0);
    chk("sticky_after_20", ovf_sticky, STATS ? 1 : 0);

    // clr_stats on the edge that loads an overflowing result
    issue(-8388608, 8388608, 0, -16777216, 1);
    idle(1);
    @(posedge clk); #1;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    chk("clr_ovf_reported", ovf, 1);
    chk("clr_count", ovf_count, 0);
    chk("clr_sticky", ovf_sticky, 0);

    // Counting resumes after a clear
    issue(8388608, 8388608, 1, 16777215, 1);
    idle(5);
    chk("count_after_clr", ovf_count, STATS ? 1 : 0);
    chk("sticky_after_clr", ovf_sticky, STATS ? 1 : 0);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
